jtkcpu_shseq: RTL



---
 rtl/jtkcpu_shseq.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/jtkcpu_shseq.sv
// jtkcpu_shseq: multi-cycle shift sequencer for the count-based 16-bit
// shift/rotate instructions (LSRD, RORD, ASRD, ASLD, ROLD).
// Repeats the ALU's one-bit 16-bit shift rule `cnt` times and returns the
// final value with N/Z/V/C flags. `busy` stalls the instruction sequencer.
//
// Optional feature macro: JTKCPU_SHSEQ_FAST_EN
//   defined   -> two steps per cen edge while rc >= 2, one step when rc == 1
//   undefined -> one step per cen edge
// Results and flags are identical in both builds; only latency differs.
//
// Handshake: `start` is accepted on a cen edge while busy=0. For cnt=0 the
// result and a one-cen-cycle `done` appear on that same edge; otherwise busy
// rises there and `done` pulses on the edge that performs the last step.
// `done` is held while cen=0 and clears on the next cen edge, on which a new
// `start` may already be accepted.
module jtkcpu_shseq (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        start,
    input  logic [2:0]  kind,
    input  logic [15:0] din,
    input  logic [7:0]  cnt,
    input  logic        c_in,
    input  logic        v_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] dout,
    output logic        c_out,
    output logic        v_out,
    output logic        n_out,
    output logic        z_out
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [2:0] K_ROR = 3'd1;
    localparam logic [2:0] K_ASR = 3'd2;
    localparam logic [2:0] K_ASL = 3'd3;
    localparam logic [2:0] K_ROL = 3'd4;

    state_t      state, state_nx;

    // working registers
    logic [15:0] w, w_nx;
    logic        wc, wc_nx;
    logic        wv, wv_nx;
    logic [7:0]  rc, rc_nx;
    logic [2:0]  k, k_nx;
    logic        vl, vl_nx;     // v_in captured at start, reported for LSR/ROR/ASR

    // registered outputs, next values
    logic        busy_nx, done_nx;
    logic [15:0] dout_nx;
    logic        c_nx, v_nx, n_nx, z_nx;

    // step results: {v, c, w}
    logic [17:0] s1;
    logic [17:0] sr;
    logic [7:0]  rc_step;
    logic        uses_v;
`ifdef JTKCPU_SHSEQ_FAST_EN
    logic [17:0] s2;
`endif

    // One bit of shift, same rules as the ALU's 16-bit shifts.
    // Kinds 5-7 fall into the LSR branch.
    function automatic logic [17:0] shift_step(input logic [2:0]  kd,
                                               input logic [15:0] x,
                                               input logic        c,
                                               input logic        v);
        logic [15:0] y;
        logic        cy;
        logic        vy;
        y  = x;
        cy = c;
        vy = v;
        case (kd)
            K_ROR: begin
                y  = {c, x[15:1]};
                cy = x[0];
            end
            K_ASR: begin
                y  = {x[15], x[15:1]};
                cy = x[0];
            end
            K_ASL: begin
                y  = {x[14:0], 1'b0};
                cy = x[15];
                vy = v | (x[15] ^ x[14]);
            end
            K_ROL: begin
                y  = {x[14:0], c};
                cy = x[15];
                vy = v | (x[15] ^ x[14]);
            end
            default: begin
                y  = {1'b0, x[15:1]};
                cy = x[0];
            end
        endcase
        return {vy, cy, y};
    endfunction

    // Per-edge step: one step, or two when the fast build has rc >= 2
    always_comb begin
        s1 = shift_step(k, w, wc, wv);
`ifdef JTKCPU_SHSEQ_FAST_EN
        s2 = shift_step(k, s1[15:0], s1[16], s1[17]);
        if (rc >= 8'd2) begin
            sr      = s2;
            rc_step = rc - 8'd2;
        end else begin
            sr      = s1;
            rc_step = rc - 8'd1;
        end
`else
        sr      = s1;
        rc_step = rc - 8'd1;
`endif
        uses_v = (k == K_ASL) || (k == K_ROL);
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx = state;
        w_nx     = w;
        wc_nx    = wc;
        wv_nx    = wv;
        rc_nx    = rc;
        k_nx     = k;
        vl_nx    = vl;
        busy_nx  = busy;
        done_nx  = 1'b0;
        dout_nx  = dout;
        c_nx     = c_out;
        v_nx     = v_out;
        n_nx     = n_out;
        z_nx     = z_out;
        case (state)
            IDLE: begin
                if (start) begin
                    w_nx  = din;
                    wc_nx = c_in;
                    wv_nx = 1'b0;
                    rc_nx = cnt;
                    k_nx  = kind;
                    vl_nx = v_in;
                    if (cnt == 8'd0) begin
                        // nothing to shift: flags pass through unchanged
                        done_nx = 1'b1;
                        dout_nx = din;
                        c_nx    = c_in;
                        v_nx    = v_in;
                        n_nx    = din[15];
                        z_nx    = (din == 16'h0000);
                    end else begin
                        state_nx = SHIFT;
                        busy_nx  = 1'b1;
                    end
                end
            end
            SHIFT: begin
                w_nx  = sr[15:0];
                wc_nx = sr[16];
                wv_nx = sr[17];
                rc_nx = rc_step;
                if (rc_step == 8'd0) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    dout_nx  = sr[15:0];
                    c_nx     = sr[16];
                    v_nx     = uses_v ? sr[17] : vl;
                    n_nx     = sr[15];
                    z_nx     = (sr[15:0] == 16'h0000);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (cen) begin
            state <= state_nx;
        end
    end

    // Working registers and held outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w     <= 16'h0000;
            wc    <= 1'b0;
            wv    <= 1'b0;
            rc    <= 8'd0;
            k     <= 3'd0;
            vl    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            dout  <= 16'h0000;
            c_out <= 1'b0;
            v_out <= 1'b0;
            n_out <= 1'b0;
            z_out <= 1'b1;
        end else if (cen) begin
            w     <= w_nx;
            wc    <= wc_nx;
            wv    <= wv_nx;
            rc    <= rc_nx;
            k     <= k_nx;
            vl    <= vl_nx;
            busy  <= busy_nx;
            done  <= done_nx;
            dout  <= dout_nx;
            c_out <= c_nx;
            v_out <= v_nx;
            n_out <= n_nx;
            z_out <= z_nx;
        end
    end

endmodule
